fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 110 +++++++++++
 tb/tb_fetch_unit.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: 2-entry response buffer feeding the IF/ID register, with redirect and flush.
// Optional macro FETCH_BYPASS_EN forwards a response arriving into an empty buffer straight to out_*.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc4
);

    logic [31:0] fetch_pc;
    logic        inflight;
    logic [31:0] inflight_pc;
    logic [31:0] buf_instr [DEPTH];
    logic [31:0] buf_pc    [DEPTH];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count;
    logic        bypass;
    logic        xfer;
    logic        pop;
    logic        wr_en;
    logic [2:0]  occ;
    logic        unused_ok;

    // The low address bits of a redirect target are forced to zero.
    assign unused_ok = ^redirect_pc[1:0];

`ifdef FETCH_BYPASS_EN
    // A wrong-path response arriving with a redirect is never forwarded.
    assign bypass = (count == 2'd0) && inflight && !redirect && !reset;
`else
    assign bypass = 1'b0;
`endif

    assign out_valid = (count != 2'd0) || bypass;
    assign xfer      = out_valid && out_ready;
    assign pop       = xfer && !bypass;
    assign wr_en     = inflight && !redirect && !(bypass && out_ready);

    // Occupancy the next cycle will see if no new request issues now.
    assign occ       = {1'b0, count} + {2'b00, inflight} - {2'b00, xfer};
    assign imem_req  = !reset && !redirect && (occ < 3'(DEPTH));
    assign imem_addr = fetch_pc;

    always_comb begin
        out_instr = 32'h0;
        out_pc    = 32'h0;
        out_pc4   = 32'h0;
        if (bypass) begin
            out_instr = imem_rdata;
            out_pc    = inflight_pc;
            out_pc4   = inflight_pc + 32'd4;
        end else if (count != 2'd0) begin
            out_instr = buf_instr[rd_ptr];
            out_pc    = buf_pc[rd_ptr];
            out_pc4   = buf_pc[rd_ptr] + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= 32'h0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            count       <= 2'd0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_instr[i] <= 32'h0;
                buf_pc[i]    <= 32'h0;
            end
        end else begin
            inflight    <= imem_req;
            inflight_pc <= fetch_pc;
            if (redirect) begin
                fetch_pc <= {redirect_pc[31:2], 2'b00};
                rd_ptr   <= 1'b0;
                wr_ptr   <= 1'b0;
                count    <= 2'd0;
            end else begin
                if (imem_req)
                    fetch_pc <= fetch_pc + 32'd4;
                if (wr_en) begin
                    buf_instr[wr_ptr] <= imem_rdata;
                    buf_pc[wr_ptr]    <= inflight_pc;
                    wr_ptr            <= ~wr_ptr;
                end
                if (pop)
                    rd_ptr <= ~rd_ptr;
                case ({wr_en, pop})
                    2'b10:   count <= count + 2'd1;
                    2'b01:   count <= count - 2'd1;
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected PC stream queued per fetch phase, popped on each transfer.
module tb_fetch_unit;

    localparam logic [31:0] RPC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc4;

    int ntests = 0;
    int nfail  = 0;
    int nxfer  = 0;
    logic [31:0] exp_q [$];

    fetch_unit #(.RESET_PC(RPC), .DEPTH(2)) dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .out_pc4(out_pc4)
    );

    always #5 clk = ~clk;

    // Memory returns the request address as the instruction word, one cycle later.
    always @(posedge clk) imem_rdata <= imem_req ? imem_addr : 32'hDEAD_BEEF;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic refill(input logic [31:0] start);
        logic [31:0] a;
        exp_q.delete();
        a = start;
        for (int i = 0; i < 64; i++) begin
            exp_q.push_back(a);
            a = a + 32'd4;
        end
    endtask

    task automatic step(input logic r, input logic rd, input logic [31:0] rpc, input logic rdy);
        reset       = r;
        redirect    = rd;
        redirect_pc = rpc;
        out_ready   = rdy;
        #1;
    endtask

    task automatic advance();
        logic [31:0] e;
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("xfer_unexpected", 32'h1, 32'h0);
            end else begin
                e = exp_q.pop_front();
                chk("out_pc", out_pc, e);
                chk("out_instr", out_instr, e);
                chk("out_pc4", out_pc4, e + 32'd4);
                nxfer++;
            end
        end
        if (reset)
            refill(RPC);
        else if (redirect)
            refill({redirect_pc[31:2], 2'b00});
        @(negedge clk);
    endtask

    task automatic run(input int n, input logic rdy);
        repeat (n) begin
            step(1'b0, 1'b0, 32'h0, rdy);
            advance();
        end
    endtask

    initial begin
        int s;
        logic [31:0] held;
        @(negedge clk);
        step(1'b1, 1'b0, 32'h0, 1'b1); advance();
        step(1'b1, 1'b0, 32'h0, 1'b1);
        chk("rst_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_pc", out_pc, 32'h0);
        chk("rst_instr", out_instr, 32'h0);
        chk("rst_pc4", out_pc4, 32'h0);
        advance();

        // First fetches after release.
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("c0_req", {31'h0, imem_req}, 32'h1);
        chk("c0_addr", imem_addr, RPC);
        chk("c0_valid", {31'h0, out_valid}, 32'h0);
        advance();
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("c1_addr", imem_addr, RPC + 32'd4);
`ifdef FETCH_BYPASS_EN
        chk("c1_valid", {31'h0, out_valid}, 32'h1);
`else
        chk("c1_valid", {31'h0, out_valid}, 32'h0);
`endif
        advance();
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("c2_valid", {31'h0, out_valid}, 32'h1);
        s = nxfer;
        advance();
        run(7, 1'b1);
        chk("tput_cnt", nxfer - s, 32'd8);

        // Stall: outputs hold, buffer fills, issue stops.
        step(1'b0, 1'b0, 32'h0, 1'b0);
        held = out_pc;
        chk("stall_valid", {31'h0, out_valid}, 32'h1);
        advance();
        for (int i = 1; i < 5; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0);
            chk("stall_hold", out_pc, held);
            if (i == 4) chk("stall_req", {31'h0, imem_req}, 32'h0);
            advance();
        end
        s = nxfer;
        run(6, 1'b1);
        chk("release_cnt", nxfer - s, 32'd6);

        // Redirect with a request in flight; low target bits dropped.
        step(1'b0, 1'b1, 32'h0000_4003, 1'b1);
        chk("rdr_req", {31'h0, imem_req}, 32'h0);
        advance();
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("rdr_addr", imem_addr, 32'h0000_4000);
        s = nxfer;
        advance();
        run(7, 1'b1);
        chk("rdr_cnt", {31'h0, (nxfer - s) >= 5}, 32'h1);

        // Back-to-back redirects: only the last target is fetched.
        step(1'b0, 1'b1, 32'h0000_5000, 1'b1); advance();
        step(1'b0, 1'b1, 32'h0000_6000, 1'b1); advance();
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("b2b_addr", imem_addr, 32'h0000_6000);
        advance();
        run(6, 1'b1);

        // Wrap at the top of the address space.
        step(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1); advance();
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("wrap_a0", imem_addr, 32'hFFFF_FFF8); advance();
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("wrap_a1", imem_addr, 32'hFFFF_FFFC); advance();
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("wrap_a2", imem_addr, 32'h0000_0000);
        s = nxfer;
        advance();
        run(6, 1'b1);
        chk("wrap_cnt", {31'h0, (nxfer - s) >= 5}, 32'h1);

        // Reset over a full buffer and a concurrent redirect.
        run(4, 1'b0);
        step(1'b1, 1'b1, 32'h0000_7000, 1'b1); advance();
        step(1'b1, 1'b0, 32'h0, 1'b1);
        chk("rst2_valid", {31'h0, out_valid}, 32'h0);
        chk("rst2_req", {31'h0, imem_req}, 32'h0);
        advance();
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("rst2_addr", imem_addr, RPC);
        s = nxfer;
        advance();
        run(8, 1'b1);
        chk("rst2_cnt", {31'h0, (nxfer - s) >= 6}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
